// File: rtl/multicycle_seq.sv
// ---------------------------------------------------------------------------
// multicycle_seq : multi-cycle RV32 control sequencer (fetch/decode/exec/mem/trap/halt)
// Rev 1.0 | optional retired-instruction counter: MULTICYCLE_SEQ_INSTRET_EN
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_seq #(
  parameter int MEM_TIMEOUT      = 15,
  parameter int CNT_W            = 32,
  parameter int TRAP_ON_MISALIGN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_resp,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [1:0]       addr_lo,
  input  logic             halt_req,
  output logic [3:0]       state_o,
  output logic             load_pc,
  output logic             load_ir,
  output logic             load_regfile,
  output logic             load_mar,
  output logic             load_mdr,
  output logic             load_data_out,
  output logic [1:0]       pc_sel,
  output logic             mem_read,
  output logic             mem_write,
  output logic [3:0]       mem_byte_enable,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic             retired,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef enum logic [3:0] {
    S_FETCH1 = 4'd0,
    S_FETCH2 = 4'd1,
    S_FETCH3 = 4'd2,
    S_DECODE = 4'd3,
    S_EXEC   = 4'd4,
    S_ADDR   = 4'd5,
    S_LD     = 4'd6,
    S_ST     = 4'd7,
    S_WB     = 4'd8,
    S_TRAP   = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  typedef struct packed {
    logic       load_pc;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_data_out;
    logic [1:0] pc_sel;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] mem_byte_enable;
    logic       trap;
    logic       retired;
  } ctl_t;

  localparam ctl_t CTL_IDLE   = '{mem_byte_enable: 4'b1111, default: '0};
  localparam ctl_t CTL_FETCH1 = '{load_mar: 1'b1, mem_byte_enable: 4'b1111, default: '0};

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [1:0]          cause_q, cause_d;
  ctl_t                ctl_q, ctl_d;

  logic is_load, is_store, is_br, is_jump, is_exec, is_legal;
  logic misaligned, timeout, waiting;
  logic [3:0] st_be;
  logic unused_funct7;

  assign unused_funct7 = ^funct7;

  always_comb begin
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    is_br    = (opcode == OP_BR);
    is_jump  = (opcode == OP_JAL) || (opcode == OP_JALR);
    is_exec  = (opcode == OP_LUI) || (opcode == OP_AUIPC) || is_jump || is_br ||
               (opcode == OP_IMM) || (opcode == OP_REG);
    is_legal = (is_load  && (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111)) ||
               (is_store && (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11)) ||
               (is_br    && (funct3 != 3'b010) && (funct3 != 3'b011)) ||
               (is_exec  && !is_br);
    // funct3[1:0] gives the access size for both loads (incl. unsigned) and stores
    misaligned = ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00)) ||
                 ((funct3[1:0] == 2'b01) && addr_lo[0]);
    case (funct3[1:0])
      2'b10:   st_be = 4'b1111;
      2'b01:   st_be = 4'b0011 << addr_lo;
      default: st_be = 4'b0001 << addr_lo;
    endcase
    waiting = (state_q == S_FETCH2) || (state_q == S_LD) || (state_q == S_ST);
    timeout = (MEM_TIMEOUT != 0) && !mem_resp &&
              (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    wait_d  = '0;
    ctl_d   = CTL_IDLE;

    case (state_q)
      S_FETCH1: state_d = halt_req ? S_HALT : S_FETCH2;
      S_FETCH2: begin
        if (mem_resp) begin
          state_d = S_FETCH3;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: begin
        if (!is_legal) begin
          state_d = S_TRAP;
          cause_d = 2'd0;
        end else if (is_load || is_store) begin
          state_d = S_ADDR;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = S_FETCH1;
      S_ADDR: begin
        if (misaligned && (TRAP_ON_MISALIGN != 0)) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          state_d = is_store ? S_ST : S_LD;
        end
      end
      S_LD, S_ST: begin
        if (mem_resp) begin
          state_d = S_WB;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_WB:     state_d = S_FETCH1;
      S_TRAP:   state_d = S_FETCH1;
      S_HALT:   state_d = halt_req ? S_HALT : S_FETCH1;
      default:  state_d = S_FETCH1;
    endcase

    // Remaining in a wait state means no response arrived this cycle
    if (waiting && (state_d == state_q)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    // Outputs are registered, so they are decoded from the state being entered
    case (state_d)
      S_FETCH1: ctl_d.load_mar = 1'b1;
      S_FETCH2: begin
        ctl_d.mem_read = 1'b1;
        ctl_d.load_mdr = 1'b1;
      end
      S_FETCH3: ctl_d.load_ir = 1'b1;
      S_EXEC: begin
        ctl_d.load_pc      = 1'b1;
        ctl_d.load_regfile = !is_br;
        ctl_d.pc_sel       = is_br ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
        ctl_d.retired      = 1'b1;
      end
      S_ADDR: begin
        ctl_d.load_mar      = 1'b1;
        ctl_d.load_data_out = is_store;
      end
      S_LD: begin
        ctl_d.mem_read = 1'b1;
        ctl_d.load_mdr = 1'b1;
      end
      S_ST: begin
        ctl_d.mem_write       = 1'b1;
        ctl_d.mem_byte_enable = st_be;
      end
      S_WB: begin
        ctl_d.load_pc      = 1'b1;
        ctl_d.load_regfile = is_load;
        ctl_d.retired      = 1'b1;
      end
      S_TRAP: begin
        ctl_d.trap    = 1'b1;
        ctl_d.load_pc = 1'b1;
        ctl_d.pc_sel  = 2'd3;
      end
      default: ctl_d = CTL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH1;
      wait_q  <= '0;
      cause_q <= 2'd0;
      ctl_q   <= CTL_FETCH1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      ctl_q   <= ctl_d;
    end
  end

`ifdef MULTICYCLE_SEQ_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q + CNT_W'(ctl_q.retired);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

  assign state_o         = state_q;
  assign load_pc         = ctl_q.load_pc;
  assign load_ir         = ctl_q.load_ir;
  assign load_regfile    = ctl_q.load_regfile;
  assign load_mar        = ctl_q.load_mar;
  assign load_mdr        = ctl_q.load_mdr;
  assign load_data_out   = ctl_q.load_data_out;
  assign pc_sel          = ctl_q.pc_sel;
  assign mem_read        = ctl_q.mem_read;
  assign mem_write       = ctl_q.mem_write;
  assign mem_byte_enable = ctl_q.mem_byte_enable;
  assign trap            = ctl_q.trap;
  assign trap_cause      = cause_q;
  assign retired         = ctl_q.retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_seq.sv
// ---------------------------------------------------------------------------
// tb_multicycle_seq : instruction-level trace model vs. multicycle_seq outputs
// Rev 1.0 | honours MULTICYCLE_SEQ_INSTRET_EN for the instret expectation
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_seq;

  localparam int MT = 4;
  localparam int CW = 8;
`ifdef MULTICYCLE_SEQ_INSTRET_EN
  localparam bit IRET = 1'b1;
`else
  localparam bit IRET = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_resp = 1'b0;
  logic          halt_req = 1'b0;
  logic [6:0]    opcode = '0;
  logic [6:0]    funct7 = '0;
  logic [2:0]    funct3 = '0;
  logic [1:0]    addr_lo = '0;
  logic [3:0]    state_o;
  logic          load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  logic [1:0]    pc_sel;
  logic          mem_read, mem_write;
  logic [3:0]    mem_byte_enable;
  logic          trap;
  logic [1:0]    trap_cause;
  logic          retired;
  logic [CW-1:0] instret;

  multicycle_seq #(.MEM_TIMEOUT(MT), .CNT_W(CW), .TRAP_ON_MISALIGN(1)) dut (
    .clk(clk), .rst(rst), .mem_resp(mem_resp), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .addr_lo(addr_lo), .halt_req(halt_req), .state_o(state_o),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
    .pc_sel(pc_sel), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .trap(trap), .trap_cause(trap_cause),
    .retired(retired), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       lpc, lir, lrf, lmar, lmdr, ldo;
    logic [1:0] psel;
    logic       mrd, mwr;
    logic [3:0] be;
    logic       trp;
    logic [1:0] cause;
    logic       ret;
    int         cnt;
    logic       resp, halt, rst_now;
    logic [6:0] op;
    logic [2:0] f3;
    logic [1:0] alo;
  } cyc_t;

  cyc_t exp_q[$];
  cyc_t obs_q[$];
  int checks = 0;
  int failures = 0;
  int m_cnt = 0;
  logic [1:0] m_cause = 2'd0;
  logic [6:0] cur_op = '0;
  logic [2:0] cur_f3 = '0;
  logic [1:0] cur_alo = '0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  function automatic cyc_t base(input logic [3:0] st);
    cyc_t c;
    c.st = st; c.lpc = 0; c.lir = 0; c.lrf = 0; c.lmar = 0; c.lmdr = 0; c.ldo = 0;
    c.psel = 0; c.mrd = 0; c.mwr = 0; c.be = 4'hF; c.trp = 0; c.cause = 0; c.ret = 0;
    c.cnt = 0; c.resp = 0; c.halt = 0; c.rst_now = 0;
    c.op = cur_op; c.f3 = cur_f3; c.alo = cur_alo;
    return c;
  endfunction

  function automatic int access_bytes();
    return 1 << cur_f3[1:0];
  endfunction

  function automatic logic [3:0] store_mask();
    int nb = access_bytes();
    int mask = ((1 << nb) - 1) << cur_alo;
    return 4'(mask);
  endfunction

  task automatic emit(input cyc_t c);
    c.cause = m_cause;
    c.cnt   = IRET ? (m_cnt % (1 << CW)) : 0;
    exp_q.push_back(c);
    if (c.ret) m_cnt++;
  endtask

  task automatic do_trap(input logic [1:0] cause);
    cyc_t c;
    m_cause = cause;
    c = base(4'd9); c.trp = 1; c.lpc = 1; c.psel = 2'd3;
    emit(c);
  endtask

  // One memory wait phase: response on cycle 'lat', timeout after MT cycles,
  // optional reset on cycle 'rst_at'.
  task automatic wait_phase(input logic [3:0] st, input int lat, input int rst_at, output bit ok);
    cyc_t c;
    ok = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      c = base(st);
      if (st == 4'd7) begin c.mwr = 1; c.be = store_mask(); end
      else begin c.mrd = 1; c.lmdr = 1; end
      c.resp = (i == lat);
      if (i == rst_at) begin
        c.resp = 0; c.rst_now = 1;
        emit(c);
        m_cnt = 0; m_cause = 2'd0;
        return;
      end
      emit(c);
      if (c.resp) begin ok = 1'b1; return; end
      if (i == MT) begin do_trap(2'd1); return; end
    end
  endtask

  // class: 0 illegal, 1 load, 2 store, 3 branch, 4 jump, 5 other exec
  function automatic int op_class(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'h03: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? 1 : 0;
      7'h23: return (f3 <= 3'd2) ? 2 : 0;
      7'h63: return (f3 inside {3'd2, 3'd3}) ? 0 : 3;
      7'h6F, 7'h67: return 4;
      7'h37, 7'h17, 7'h13, 7'h33: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic run_instr(input int h, input int f, input logic [6:0] op, input logic [2:0] f3,
                           input logic [1:0] alo, input int m, input int rst_at);
    cyc_t c;
    bit ok;
    int cls;
    cur_op = op; cur_f3 = f3; cur_alo = alo;
    c = base(4'd0); c.lmar = 1; c.halt = (h > 0); emit(c);
    if (h > 0) begin
      for (int i = 1; i <= h; i++) begin c = base(4'd10); c.halt = (i < h); emit(c); end
      c = base(4'd0); c.lmar = 1; emit(c);
    end
    wait_phase(4'd1, f, 0, ok);
    if (!ok) return;
    c = base(4'd2); c.lir = 1; emit(c);
    c = base(4'd3); emit(c);
    cls = op_class(op, f3);
    if (cls == 0) begin do_trap(2'd0); return; end
    if (cls >= 3) begin
      c = base(4'd4); c.lpc = 1; c.lrf = (cls != 3); c.ret = 1;
      c.psel = (cls == 3) ? 2'd1 : ((cls == 4) ? 2'd2 : 2'd0);
      emit(c);
      return;
    end
    c = base(4'd5); c.lmar = 1; c.ldo = (cls == 2); emit(c);
    if ((alo % access_bytes()) != 0) begin do_trap(2'd2); return; end
    wait_phase((cls == 2) ? 4'd7 : 4'd6, m, rst_at, ok);
    if (!ok) return;
    c = base(4'd8); c.lpc = 1; c.lrf = (cls == 1); c.ret = 1; emit(c);
  endtask

  task automatic step(input cyc_t e, input int idx);
    cyc_t o;
    @(negedge clk);
    o = e;
    o.st = state_o; o.lpc = load_pc; o.lir = load_ir; o.lrf = load_regfile;
    o.lmar = load_mar; o.lmdr = load_mdr; o.ldo = load_data_out; o.psel = pc_sel;
    o.mrd = mem_read; o.mwr = mem_write; o.be = mem_byte_enable; o.trp = trap;
    o.cause = trap_cause; o.ret = retired; o.cnt = int'(instret);
    obs_q.push_back(o);
    chk("state", idx, 32'(o.st), 32'(e.st));
    chk("load_pc", idx, 32'(o.lpc), 32'(e.lpc));
    chk("load_ir", idx, 32'(o.lir), 32'(e.lir));
    chk("load_regfile", idx, 32'(o.lrf), 32'(e.lrf));
    chk("load_mar", idx, 32'(o.lmar), 32'(e.lmar));
    chk("load_mdr", idx, 32'(o.lmdr), 32'(e.lmdr));
    chk("load_data_out", idx, 32'(o.ldo), 32'(e.ldo));
    chk("pc_sel", idx, 32'(o.psel), 32'(e.psel));
    chk("mem_read", idx, 32'(o.mrd), 32'(e.mrd));
    chk("mem_write", idx, 32'(o.mwr), 32'(e.mwr));
    chk("byte_enable", idx, 32'(o.be), 32'(e.be));
    chk("trap", idx, 32'(o.trp), 32'(e.trp));
    chk("trap_cause", idx, 32'(o.cause), 32'(e.cause));
    chk("retired", idx, 32'(o.ret), 32'(e.ret));
    chk("instret", idx, 32'(o.cnt), 32'(e.cnt));
    rst = !e.rst_now; mem_resp = e.resp; halt_req = e.halt;
    opcode = e.op; funct3 = e.f3; addr_lo = e.alo; funct7 = 7'($urandom);
  endtask

  initial begin
    logic [6:0] ops [10] = '{7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h13, 7'h33, 7'h7F};
    int exp_seq [7] = '{0, 1, 1, 2, 3, 4, 0};
    int cnt1 = IRET ? 1 : 0;
    int cnt2 = IRET ? 2 : 0;
    int cnt3 = IRET ? 3 : 0;

    run_instr(0, 2, 7'h13, 3'd0, 2'd0, 1, 0);   // addi
    run_instr(0, 1, 7'h23, 3'd0, 2'd3, 2, 0);   // sb @3
    run_instr(0, 99, 7'h13, 3'd0, 2'd0, 1, 0);  // fetch timeout
    run_instr(0, 1, 7'h7F, 3'd0, 2'd0, 1, 0);   // illegal opcode
    run_instr(0, 1, 7'h03, 3'd2, 2'd2, 1, 0);   // misaligned lw
    run_instr(3, 1, 7'h13, 3'd0, 2'd0, 1, 0);   // halt, then addi
    run_instr(0, 1, 7'h03, 3'd2, 2'd0, 5, 2);   // reset during LD wait
    for (int n = 0; n < 300; n++) begin
      int pick = $urandom_range(0, 10);
      logic [6:0] op = (pick == 10) ? 7'($urandom) : ops[pick];
      int h = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      int f = $urandom_range(1, MT + 2);
      int m = $urandom_range(1, MT + 2);
      int ra = ($urandom_range(0, 15) == 0) ? $urandom_range(1, MT) : 0;
      run_instr(h, f, op, 3'($urandom), 2'($urandom), m, ra);
    end

    rst = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < exp_q.size(); i++) step(exp_q[i], i);

    if (obs_q.size() < 48) begin
      chk("trace_length", 0, 32'(obs_q.size()), 32'd48);
    end else begin
      chk("reset_state", 0, 32'(obs_q[0].st), 32'd0);
      chk("reset_load_mar", 0, 32'(obs_q[0].lmar), 32'd1);
      chk("reset_cause", 0, 32'(obs_q[0].cause), 32'd0);
      for (int i = 0; i < 7; i++) chk("addi_seq", i, 32'(obs_q[i].st), 32'(exp_seq[i]));
      chk("addi_retired", 5, 32'(obs_q[5].ret), 32'd1);
      chk("addi_instret", 6, 32'(obs_q[6].cnt), 32'(cnt1));
      chk("sb_be", 11, 32'(obs_q[11].be), 32'h8);
      chk("sb_write", 11, 32'(obs_q[11].mwr), 32'd1);
      chk("sb_be_hold", 12, 32'(obs_q[12].be), 32'h8);
      chk("sb_wb_state", 13, 32'(obs_q[13].st), 32'd8);
      chk("sb_wb_regfile", 13, 32'(obs_q[13].lrf), 32'd0);
      chk("to_last_fetch2", 18, 32'(obs_q[18].st), 32'd1);
      chk("to_trap_state", 19, 32'(obs_q[19].st), 32'd9);
      chk("to_trap", 19, 32'(obs_q[19].trp), 32'd1);
      chk("to_pc_sel", 19, 32'(obs_q[19].psel), 32'd3);
      chk("to_cause", 19, 32'(obs_q[19].cause), 32'd1);
      chk("ill_trap_state", 24, 32'(obs_q[24].st), 32'd9);
      chk("ill_cause", 24, 32'(obs_q[24].cause), 32'd0);
      chk("mis_addr", 29, 32'(obs_q[29].st), 32'd5);
      chk("mis_cause", 30, 32'(obs_q[30].cause), 32'd2);
      chk("mis_instret", 31, 32'(obs_q[31].cnt), 32'(cnt2));
      for (int i = 32; i < 35; i++) chk("halt_state", i, 32'(obs_q[i].st), 32'd10);
      chk("halt_release", 35, 32'(obs_q[35].st), 32'd0);
      chk("ld_wait", 46, 32'(obs_q[46].mrd), 32'd1);
      chk("ld_instret", 46, 32'(obs_q[46].cnt), 32'(cnt3));
      chk("rst_state", 47, 32'(obs_q[47].st), 32'd0);
      chk("rst_mem_read", 47, 32'(obs_q[47].mrd), 32'd0);
      chk("rst_instret", 47, 32'(obs_q[47].cnt), 32'd0);
      chk("rst_cause", 47, 32'(obs_q[47].cause), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
